// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents:
//   state_t / IDLE, RUN, DONE : 2-bit FSM state encoding
//   cnt_w(width)              : width of the step counter, which must hold 0..width
package seq_div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step.
// Ports:
//   r      in   WIDTH    current partial remainder
//   q_msb  in   1        next dividend bit to shift into the remainder
//   d      in   WIDTH    divisor
//   r_next out  WIDTH    partial remainder after the step
//   q_bit  out  1        quotient bit produced by the step
// The trial value and the subtract are WIDTH+1 bits wide, so a divisor with
// its top bit set still compares correctly. The restored remainder is always
// smaller than the divisor, so it fits back into WIDTH bits.
module seq_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial  = {r, q_msb};
    assign diff   = trial - {1'b0, d};
    // Non-negative difference: the divisor fits, keep the difference.
    assign q_bit  = ~diff[WIDTH];
    assign r_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring unsigned divider with valid/ready handshakes.
// Result (out = quotient, rem = remainder) is valid WIDTH+1 edges after accept.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      unit idle, can accept operands
//   in1        in   WIDTH  dividend
//   in2        in   WIDTH  divisor
//   out_valid  out  1      out/rem hold a result
//   out_ready  in   1      consumer takes the result
//   out        out  WIDTH  quotient
//   rem        out  WIDTH  remainder
//   busy       out  1      division in progress or result pending
//   div_zero   out  1      divisor was zero (only with SEQ_DIV_ZERO_FLAG_EN)
// Build option: define SEQ_DIV_ZERO_FLAG_EN to short-cut zero divisors and
// report them on div_zero.
module seq_div_unit
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rem,
    output logic             busy
`ifdef SEQ_DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] r_step;
    logic             q_bit;
    logic             accept;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic             zero_reg;
`endif

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .d      (d_reg),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            d_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            out       <= '0;
            rem       <= '0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
            zero_reg  <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        d_reg     <= in2;
                        q_reg     <= in1;
                        r_reg     <= '0;
                        cnt_reg   <= CW'(WIDTH);
                        state_reg <= RUN;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                        // Zero divisor: preload the final answer and skip
                        // every step; the result registers on the next edge.
                        zero_reg  <= (in2 == '0);
                        if (in2 == '0) begin
                            q_reg   <= '1;
                            r_reg   <= in1;
                            cnt_reg <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    if (cnt_reg != '0) begin
                        r_reg   <= r_step;
                        q_reg   <= {q_reg[WIDTH-2:0], q_bit};
                        cnt_reg <= cnt_reg - CW'(1);
                    end else begin
                        out       <= q_reg;
                        rem       <= r_reg;
                        state_reg <= DONE;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                        div_zero  <= zero_reg;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                        div_zero  <= 1'b0;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_unit.sv
`timescale 1ns/1ps
module tb_seq_div_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [W-1:0] rem;
    logic         busy;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic         div_zero;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .rem       (rem),
        .busy      (busy)
`ifdef SEQ_DIV_ZERO_FLAG_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one division from a negedge, wait for the result, optionally
    // stall the consumer for 'hold' cycles, then drain. Returns at a negedge.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        int           exp_lat;
        int           lat;
        logic [63:0]  recon;

        // Reference: plain unsigned division; zero divisor yields all ones / dividend.
        if (b == '0) begin
            exp_q = '1;
            exp_r = a;
        end else begin
            exp_q = a / b;
            exp_r = a % b;
        end
        exp_lat = W + 1;
`ifdef SEQ_DIV_ZERO_FLAG_EN
        if (b == '0) exp_lat = 1;
`endif

        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = W'($urandom);
        in2 = W'($urandom);
        @(negedge clk);
        check("in_ready_busy", in_ready, 1'b0);
        check("busy_run", busy, 1'b1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("div %0d / %0d -> q=%0d r=%0d latency=%0d", a, b, out, rem, lat);
        check("latency", 64'(lat), 64'(exp_lat));
        check("quotient", out, exp_q);
        check("remainder", rem, exp_r);
`ifdef SEQ_DIV_ZERO_FLAG_EN
        check("div_zero", div_zero, (b == '0));
`endif
        if (b != '0) begin
            recon = 64'(out) * 64'(b) + 64'(rem);
            check("identity", recon, 64'(a));
            check("rem_lt_div", (rem < b), 1'b1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_q", out, exp_q);
            check("hold_r", rem, exp_r);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", out_valid, 1'b0);
        check("drain_in_ready", in_ready, 1'b1);
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         seen_valid;

        reset = 1'b1;
        in_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out", out, '0);
        check("rst_rem", rem, '0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_div(16'd100, 16'd7, 0);
        run_div(16'hFFFF, 16'd1, 0);
        run_div(16'd5, 16'd9, 0);
        run_div(16'h1234, 16'd0, 0);
        run_div(16'd0, 16'd5, 0);
        run_div(16'hFFFF, 16'h8000, 0);
        run_div(16'd1000, 16'd13, 10);

        // Asynchronous reset in the middle of a division.
        in_valid = 1'b1;
        in1 = 16'd5000;
        in2 = 16'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_out", out, '0);
        check("midrst_rem", rem, '0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("discarded_result", seen_valid, 1'b0);
        run_div(16'd200, 16'd3, 0);

        // Random full-width operands, occasional zero divisor and stalls.
        for (int n = 0; n < 120; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 255));
            run_div(ra, rb, int'($urandom_range(0, 2)));
        end
        // Random 8-bit operands with non-zero divisors.
        for (int n = 0; n < 80; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            run_div(ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
